dcache_direct_wb: RTL

//  Direct-mapped, write-back, write-allocate L1 data cache between the pipeline D-cache port
//  (DCACHE_ren/wen/addr/wdata/rdata/stall) and a slow 128-bit block memory. Hits complete

---
 rtl/dcache_pkg.sv | 27 ++
 rtl/dcache_line_array.sv | 61 ++++++
 rtl/dcache_direct_wb.sv | 126 ++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types and field geometry for the direct-mapped write-back D-cache
package dcache_pkg;

    typedef enum logic [1:0] {
        COMPARE,
        WRITEBACK,
        ALLOCATE,
        REFILLED
    } state_t;

    localparam int DEF_NUM_BLOCKS  = 8;
    localparam int DEF_WORD_W      = 32;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int OFFSET_W        = 2;
    localparam int ADDR_W          = 30;
    localparam int MEM_ADDR_W      = ADDR_W - OFFSET_W;
    localparam int BLOCK_W         = WORDS_PER_BLOCK * DEF_WORD_W;
    localparam int INDEX_W         = $clog2(DEF_NUM_BLOCKS);
    localparam int INDEX_LSB       = OFFSET_W;
    localparam int TAG_LSB         = OFFSET_W + INDEX_W;
    localparam int TAG_W           = ADDR_W - TAG_LSB;

    function automatic int word_lsb(input logic [OFFSET_W-1:0] offset, input int word_w);
        return int'(offset) * word_w;
    endfunction

endpackage

// File: rtl/dcache_line_array.sv
// rtl/dcache_line_array.sv - valid/dirty/tag/data storage with combinational read and one sync write port
module dcache_line_array
    import dcache_pkg::*;
#(
    parameter int NUM_BLOCKS = DEF_NUM_BLOCKS,
    parameter int WORD_W     = DEF_WORD_W,
    parameter int BLK_W      = BLOCK_W,
    parameter int IDX_W      = $clog2(NUM_BLOCKS),
    parameter int LINE_TAG_W = ADDR_W - OFFSET_W - IDX_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IDX_W-1:0]      index,
    output logic                  valid,
    output logic                  dirty,
    output logic [LINE_TAG_W-1:0] tag,
    output logic [BLK_W-1:0]      line,
    input  logic                  word_we,
    input  logic [OFFSET_W-1:0]   offset,
    input  logic [WORD_W-1:0]     word_data,
    input  logic                  fill_we,
    input  logic [LINE_TAG_W-1:0] fill_tag,
    input  logic [BLK_W-1:0]      fill_line,
    input  logic                  clean_we
);

    logic [NUM_BLOCKS-1:0] valid_q;
    logic [NUM_BLOCKS-1:0] dirty_q;
    logic [LINE_TAG_W-1:0] tag_q  [NUM_BLOCKS];
    logic [BLK_W-1:0]      data_q [NUM_BLOCKS];

    assign valid = valid_q[index];
    assign dirty = dirty_q[index];
    assign tag   = tag_q[index];
    assign line  = data_q[index];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_we) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
        end else if (word_we) begin
            dirty_q[index] <= 1'b1;
        end else if (clean_we) begin
            dirty_q[index] <= 1'b0;
        end
    end

    // Tag and data are deliberately left unreset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[index]  <= fill_tag;
            data_q[index] <= fill_line;
        end else if (word_we) begin
            data_q[index][word_lsb(offset, WORD_W) +: WORD_W] <= word_data;
        end
    end

endmodule

// File: rtl/dcache_direct_wb.sv
// rtl/dcache_direct_wb.sv - direct-mapped write-back write-allocate L1 D-cache with miss FSM
module dcache_direct_wb
    import dcache_pkg::*;
#(
    parameter int NUM_BLOCKS = DEF_NUM_BLOCKS,
    parameter int WORD_W     = DEF_WORD_W
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                proc_read,
    input  logic                                proc_write,
    input  logic [ADDR_W-1:0]                   proc_addr,
    input  logic [WORD_W-1:0]                   proc_wdata,
    output logic [WORD_W-1:0]                   proc_rdata,
    output logic                                proc_stall,
    output logic                                mem_read,
    output logic                                mem_write,
    output logic [MEM_ADDR_W-1:0]               mem_addr,
    output logic [WORDS_PER_BLOCK*WORD_W-1:0]   mem_wdata,
    input  logic [WORDS_PER_BLOCK*WORD_W-1:0]   mem_rdata,
    input  logic                                mem_ready
);

    localparam int IDX_W      = $clog2(NUM_BLOCKS);
    localparam int LINE_TAG_W = ADDR_W - OFFSET_W - IDX_W;
    localparam int BLK_W      = WORDS_PER_BLOCK * WORD_W;

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic [LINE_TAG_W-1:0]   addr_tag;
    logic [OFFSET_W-1:0]     offset;
    logic [MEM_ADDR_W-1:0]   block_addr;
    logic                    line_valid;
    logic                    line_dirty;
    logic [LINE_TAG_W-1:0]   line_tag;
    logic [BLK_W-1:0]        line_data;
    logic                    req;
    logic                    hit;
    logic                    word_we;
    logic                    fill_we;
    logic                    clean_we;

    assign idx        = proc_addr[OFFSET_W +: IDX_W];
    assign addr_tag   = proc_addr[OFFSET_W + IDX_W +: LINE_TAG_W];
    assign offset     = proc_addr[OFFSET_W-1:0];
    assign block_addr = proc_addr[ADDR_W-1:OFFSET_W];

    assign req = proc_read | proc_write;
    assign hit = line_valid & (line_tag == addr_tag);

    // Write wins over read when both are asserted; the read still sees the pre-write word.
    assign word_we  = rst_n & (state == COMPARE) & req & hit & proc_write;
    assign fill_we  = rst_n & (state == ALLOCATE) & mem_ready;
    assign clean_we = rst_n & (state == WRITEBACK) & mem_ready;

    assign proc_stall = rst_n & ((state != COMPARE) | (req & ~hit));
    assign proc_rdata = rst_n ? line_data[word_lsb(offset, WORD_W) +: WORD_W] : '0;

    dcache_line_array #(
        .NUM_BLOCKS (NUM_BLOCKS),
        .WORD_W     (WORD_W),
        .BLK_W      (BLK_W),
        .IDX_W      (IDX_W),
        .LINE_TAG_W (LINE_TAG_W)
    ) u_lines (
        .clk       (clk),
        .rst_n     (rst_n),
        .index     (idx),
        .valid     (line_valid),
        .dirty     (line_dirty),
        .tag       (line_tag),
        .line      (line_data),
        .word_we   (word_we),
        .offset    (offset),
        .word_data (proc_wdata),
        .fill_we   (fill_we),
        .fill_tag  (addr_tag),
        .fill_line (mem_rdata),
        .clean_we  (clean_we)
    );

    // Memory-side outputs are registered on entry to each state so they hold steady for the request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= COMPARE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                COMPARE: begin
                    if (req && !hit) begin
                        if (line_valid && line_dirty) begin
                            state     <= WRITEBACK;
                            mem_write <= 1'b1;
                            mem_addr  <= {line_tag, idx};
                            mem_wdata <= line_data;
                        end else begin
                            state    <= ALLOCATE;
                            mem_read <= 1'b1;
                            mem_addr <= block_addr;
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ready) begin
                        state     <= ALLOCATE;
                        mem_write <= 1'b0;
                        mem_read  <= 1'b1;
                        mem_addr  <= block_addr;
                    end
                end
                ALLOCATE: begin
                    if (mem_ready) begin
                        state    <= REFILLED;
                        mem_read <= 1'b0;
                    end
                end
                REFILLED: state <= COMPARE;
                default:  state <= COMPARE;
            endcase
        end
    end

endmodule
